// File: rtl/prog_cntr_pkg.sv
// Shared definitions for the fetch-stage program counter: next-PC source
// encodings and the default address width.
package prog_cntr_pkg;

    localparam int DEFAULT_ADDR_W = 14;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'd0,
        SRC_BR  = 2'd1,
        SRC_INT = 2'd2,
        SRC_RET = 2'd3
    } pc_src_e;

endpackage

// File: rtl/prog_cntr_ras.sv
// Return-address stack: a circular buffer with a top pointer and an entry count.
// A push onto a full stack overwrites the oldest entry. A pop from an empty stack is ignored.
module prog_cntr_ras #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  wr_idx;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign top    = mem_q[ptr_q];
    assign wr_idx = ptr_q + PTR_W'(1);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            // When full, the slot after the top holds the oldest entry.
            ptr_d = wr_idx;
            if (!full) begin
                count_d = count_q + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/prog_cntr_unit.sv
// Fetch-stage program counter with a fixed-priority next-PC select and a return-address stack.
// Optional trace outputs (last_src, last_from) are enabled by PROG_CNTR_TRACE_EN.
module prog_cntr_unit
    import prog_cntr_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] branch_target_addr,
    input  logic              int_req,
    input  logic [ADDR_W-1:0] int_vector_addr,
    output logic              int_ack,
`ifdef PROG_CNTR_TRACE_EN
    output logic [1:0]        last_src,
    output logic [ADDR_W-1:0] last_from,
`endif
    output logic [ADDR_W-1:0] prog_cntr,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              int_ack_q, int_ack_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    pc_src_e           src;

    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_din, ras_top;
    logic              ras_full, ras_empty;

    assign pc_inc = pc_q + ADDR_W'(1);

    // Priority decision only; the stall gate is applied when acting on it.
    always_comb begin
        if (int_req) begin
            src = SRC_INT;
        end else if (ret) begin
            src = SRC_RET;
        end else if (branch_taken) begin
            src = SRC_BR;
        end else begin
            src = SRC_SEQ;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        int_ack_d = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_din   = pc_q;
        if (!stall) begin
            case (src)
                SRC_INT: begin
                    // Save the interrupted, not yet executed instruction.
                    pc_d      = int_vector_addr;
                    ras_push  = 1'b1;
                    ras_din   = pc_q;
                    int_ack_d = 1'b1;
                end
                SRC_RET: begin
                    ras_pop = 1'b1;
                    pc_d    = ras_empty ? RESET_VEC : ras_top;
                end
                SRC_BR: begin
                    pc_d = branch_target_addr;
                    if (call) begin
                        ras_push = 1'b1;
                        ras_din  = pc_inc;
                    end
                end
                default: pc_d = pc_inc;
            endcase
            if (ras_push && ras_full) begin
                ovf_d = 1'b1;
            end
            if (ras_pop && ras_empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VEC;
            int_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            int_ack_q <= int_ack_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    prog_cntr_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push    (ras_push),
        .pop     (ras_pop),
        .data_in (ras_din),
        .top     (ras_top),
        .full    (ras_full),
        .empty   (ras_empty)
    );

`ifdef PROG_CNTR_TRACE_EN
    logic [1:0]        last_src_q, last_src_d;
    logic [ADDR_W-1:0] last_from_q, last_from_d;

    always_comb begin
        last_src_d  = last_src_q;
        last_from_d = last_from_q;
        if (!stall && (src != SRC_SEQ)) begin
            last_src_d  = src;
            last_from_d = pc_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_src_q  <= 2'd0;
            last_from_q <= '0;
        end else begin
            last_src_q  <= last_src_d;
            last_from_q <= last_from_d;
        end
    end

    assign last_src  = last_src_q;
    assign last_from = last_from_q;
`endif

    assign prog_cntr     = pc_q;
    assign int_ack       = int_ack_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_prog_cntr_unit.sv
// Scoreboard bench for prog_cntr_unit: the driver predicts each cycle's result with a queue-based model.
// A monitor compares the prediction against the DUT after every clock edge.
module tb_prog_cntr_unit;

    localparam int AW    = 14;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0, branch_taken = 1'b0, call = 1'b0, ret = 1'b0, int_req = 1'b0;
    logic [AW-1:0] branch_target_addr = '0, int_vector_addr = '0;
    logic          int_ack, ras_overflow, ras_underflow;
    logic [AW-1:0] prog_cntr;
`ifdef PROG_CNTR_TRACE_EN
    logic [1:0]    last_src;
    logic [AW-1:0] last_from;
`endif

    prog_cntr_unit #(.ADDR_W(AW), .RAS_DEPTH(DEPTH), .RESET_VEC('0)) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .call               (call),
        .ret                (ret),
        .branch_target_addr (branch_target_addr),
        .int_req            (int_req),
        .int_vector_addr    (int_vector_addr),
        .int_ack            (int_ack),
`ifdef PROG_CNTR_TRACE_EN
        .last_src           (last_src),
        .last_from          (last_from),
`endif
        .prog_cntr          (prog_cntr),
        .ras_overflow       (ras_overflow),
        .ras_underflow      (ras_underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] pc;
        logic          ack;
        logic          ovf;
        logic          unf;
        logic [1:0]    src;
        logic [AW-1:0] from;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the return stack is just a list, newest at the back.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack[$];
    logic          m_ovf, m_unf;
    logic [1:0]    m_src;
    logic [AW-1:0] m_from;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_stack.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_src  = 2'd0;
        m_from = '0;
    endtask

    task automatic model_push(input logic [AW-1:0] addr);
        m_stack.push_back(addr);
        if (m_stack.size() > DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        {stall, branch_taken, call, ret, int_req} = '0;
        #1;
        model_reset();
        check("reset_pc", 32'(prog_cntr), 32'(m_pc));
        check("reset_flags", {29'd0, int_ack, ras_overflow, ras_underflow}, 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input logic st, input logic br, input logic cl, input logic rt,
                        input logic ir, input logic [AW-1:0] tgt, input logic [AW-1:0] vec);
        exp_t e;
        logic [AW-1:0] old_pc;
        @(negedge clock);
        stall = st; branch_taken = br; call = cl; ret = rt; int_req = ir;
        branch_target_addr = tgt; int_vector_addr = vec;
        old_pc = m_pc;
        e.ack  = 1'b0;
        if (!st) begin
            if (ir) begin
                model_push(old_pc);
                m_pc = vec; e.ack = 1'b1; m_src = 2'd2; m_from = old_pc;
            end else if (rt) begin
                if (m_stack.size() == 0) begin
                    m_pc = '0; m_unf = 1'b1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
                m_src = 2'd3; m_from = old_pc;
            end else if (br) begin
                if (cl) model_push(old_pc + 1'b1);
                m_pc = tgt; m_src = 2'd1; m_from = old_pc;
            end else begin
                m_pc = old_pc + 1'b1;
            end
        end
        e.pc = m_pc; e.ovf = m_ovf; e.unf = m_unf; e.src = m_src; e.from = m_from;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0, '0);
    endtask

    // Monitor: one popped prediction per clock edge that had one issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn t=%0t pc=%h ack=%b ovf=%b unf=%b", $time, prog_cntr, int_ack,
                         ras_overflow, ras_underflow);
                check("pc", 32'(prog_cntr), 32'(e.pc));
                check("int_ack", 32'(int_ack), 32'(e.ack));
                check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
                check("ras_underflow", 32'(ras_underflow), 32'(e.unf));
`ifdef PROG_CNTR_TRACE_EN
                check("last_src", 32'(last_src), 32'(e.src));
                check("last_from", 32'(last_from), 32'(e.from));
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        model_reset();
        do_reset();
        // Sequential run, then asynchronous reset at PC=5.
        repeat (5) idle();
        do_reset();
        repeat (3) idle();
        // Call at 0x10 to 0x100, immediate return to 0x11.
        step(0, 1, 0, 0, 0, 14'h010, '0);
        step(0, 1, 1, 0, 0, 14'h100, '0);
        step(0, 0, 0, 1, 0, '0, '0);
        idle();
        // Interrupt wins over ret; handler returns to the interrupted PC.
        step(0, 1, 0, 0, 0, 14'h020, '0);
        step(0, 0, 0, 1, 1, '0, 14'h200);
        idle();
        idle();
        step(0, 0, 0, 1, 0, '0, '0);
        // Interrupt pending across a 3-cycle stall.
        step(0, 1, 0, 0, 0, 14'h040, '0);
        repeat (3) step(1, 0, 0, 0, 1, '0, 14'h300);
        step(0, 0, 0, 0, 1, '0, 14'h300);
        step(0, 0, 0, 1, 0, '0, '0);
        // Nine nested calls overflow; nine returns underflow.
        do_reset();
        for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 14'(14'h1000 + i * 16), '0);
        repeat (9) step(0, 0, 0, 1, 0, '0, '0);
        idle();
        // Wrap from all-ones to zero.
        step(0, 1, 0, 0, 0, 14'h3FFE, '0);
        idle();
        idle();
        idle();
        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 18,
                     $urandom_range(0, 99) < 6,
                     ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom),
                     14'($urandom));
            end
        end
        @(negedge clock);
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clock);
            drain++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d predictions never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
